// File: rtl/variable_delay_line.sv
// Delays a WIDTH-bit sample and its valid qualifier by a runtime-selectable 1..MAX_DELAY cycles,
// with a synchronous flush and a settling flag after delay changes.
module variable_delay_line #(
  parameter int WIDTH       = 8,
  parameter int MAX_DELAY   = 16,
  parameter int RESET_DELAY = 1,
  parameter int DW          = $clog2(MAX_DELAY + 1)
) (
  input  logic             i_clock,
  input  logic             i_resetL,
  input  logic             i_clear,
  input  logic [DW-1:0]    i_delay,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [DW-1:0]    o_delay,
  output logic             o_settling
);

  logic [WIDTH-1:0]     data_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] v_q;
  logic [DW-1:0]        d_q;
  logic [DW-1:0]        cnt_q;
  logic [DW-1:0]        req;
  logic                 change;
  logic                 flush;

  always_comb begin
    if (i_delay == '0)
      req = DW'(1);
    else if (i_delay > DW'(MAX_DELAY))
      req = DW'(MAX_DELAY);
    else
      req = i_delay;
  end

  assign change = (req != d_q);
  assign flush  = change | i_clear;

  // Data always shifts; only the valid bits beyond stage 0 are dropped on a flush,
  // so the sample presented at the flushing edge survives.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      for (int unsigned k = 0; k < MAX_DELAY; k++)
        data_q[k] <= '0;
      v_q   <= '0;
      d_q   <= DW'(RESET_DELAY);
      cnt_q <= '0;
    end else begin
      data_q[0] <= i_data;
      for (int unsigned k = 1; k < MAX_DELAY; k++)
        data_q[k] <= data_q[k-1];

      if (flush)
        v_q <= {{(MAX_DELAY-1){1'b0}}, i_valid};
      else
        v_q <= {v_q[MAX_DELAY-2:0], i_valid};

      if (change) begin
        d_q   <= req;
        cnt_q <= req - 1'b1;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    for (int unsigned k = 0; k < MAX_DELAY; k++) begin
      if (d_q == DW'(k + 1)) begin
        o_valid = v_q[k];
        o_data  = v_q[k] ? data_q[k] : '0;
      end
    end
  end

  assign o_delay    = d_q;
  assign o_settling = (cnt_q != '0);

endmodule

// File: tb/tb_variable_delay_line.sv
// Scoreboard bench for variable_delay_line: the driver queues expected samples with their due edge,
// the monitor pops and checks whenever o_valid is seen.
module tb_variable_delay_line;

  localparam int WIDTH       = 8;
  localparam int MAX_DELAY   = 16;
  localparam int RESET_DELAY = 1;
  localparam int DW          = 5;

  logic             i_clock;
  logic             i_resetL;
  logic             i_clear;
  logic [DW-1:0]    i_delay;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic [DW-1:0]    o_delay;
  logic             o_settling;

  variable_delay_line #(
    .WIDTH      (WIDTH),
    .MAX_DELAY  (MAX_DELAY),
    .RESET_DELAY(RESET_DELAY),
    .DW         (DW)
  ) dut (
    .i_clock   (i_clock),
    .i_resetL  (i_resetL),
    .i_clear   (i_clear),
    .i_delay   (i_delay),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_delay   (o_delay),
    .o_settling(o_settling)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            errors  = 0;
  int            edge_n  = 0;
  logic [DW-1:0] mdl_d   = DW'(RESET_DELAY);

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  always @(posedge i_clock) edge_n <= edge_n + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] x);
    if (x == 0) return DW'(1);
    if (x > DW'(MAX_DELAY)) return DW'(MAX_DELAY);
    return x;
  endfunction

  // Apply one edge of stimulus; queue the sample with the edge whose following cycle must show it.
  task automatic step(input logic v, input logic [WIDTH-1:0] dat, input logic [DW-1:0] dly,
                      input logic clr);
    logic [DW-1:0] req;
    i_valid = v;
    i_data  = dat;
    i_delay = dly;
    i_clear = clr;
    @(posedge i_clock);
    #1;
    req = clamp(dly);
    if (req != mdl_d || clr) sb.delete();
    mdl_d = req;
    if (v) sb.push_back('{data: dat, due: edge_n + int'(req) - 1});
  endtask

  task automatic idle(input int n, input logic [DW-1:0] dly);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, dly, 1'b0);
  endtask

  always @(negedge i_clock) begin
    if (i_resetL) begin
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", {31'd0, o_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", {24'd0, o_data}, {24'd0, e.data});
          chk("out_latency", edge_n, e.due);
        end
      end else begin
        chk("idle_data_zero", {24'd0, o_data}, 32'd0);
        if (sb.size() != 0 && sb[0].due <= edge_n) begin
          exp_t e;
          e = sb.pop_front();
          chk("missing_output", edge_n, e.due + 1000000);
        end
      end
    end
  end

  initial begin
    i_resetL = 1'b0;
    i_clear  = 1'b0;
    i_delay  = DW'(1);
    i_valid  = 1'b0;
    i_data   = '0;
    #12;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    chk("rst_delay", {27'd0, o_delay}, 32'd1);
    chk("rst_settling", {31'd0, o_settling}, 32'd0);
    #1 i_resetL = 1'b1;

    // d=1 acts as a single flop
    step(1'b1, 8'h11, 5'd1, 1'b0);
    chk("d1_delay", {27'd0, o_delay}, 32'd1);
    chk("d1_settling", {31'd0, o_settling}, 32'd0);
    step(1'b1, 8'h22, 5'd1, 1'b0);
    step(1'b1, 8'h33, 5'd1, 1'b0);
    chk("d1_valid", {31'd0, o_valid}, 32'd1);
    idle(2, 5'd1);

    // d=5 single pulse
    step(1'b0, 8'h00, 5'd5, 1'b0);
    chk("d5_delay", {27'd0, o_delay}, 32'd5);
    chk("d5_settling_start", {31'd0, o_settling}, 32'd1);
    idle(5, 5'd5);
    chk("d5_settled", {31'd0, o_settling}, 32'd0);
    step(1'b1, 8'hA5, 5'd5, 1'b0);
    idle(7, 5'd5);

    // clamping high and low
    step(1'b0, 8'h00, 5'd19, 1'b0);
    chk("clamp_hi", {27'd0, o_delay}, 32'd16);
    step(1'b1, 8'h5A, 5'd19, 1'b0);
    idle(17, 5'd19);
    step(1'b1, 8'h3C, 5'd0, 1'b0);
    chk("clamp_lo", {27'd0, o_delay}, 32'd1);
    chk("clamp_lo_settling", {31'd0, o_settling}, 32'd0);
    idle(2, 5'd0);

    // stream at d=4, switch to 8 while presenting 0x10
    for (int i = 1; i <= 15; i++) step(1'b1, 8'(i), 5'd4, 1'b0);
    step(1'b1, 8'h10, 5'd8, 1'b0);
    chk("sw_delay", {27'd0, o_delay}, 32'd8);
    chk("sw_settling_0", {31'd0, o_settling}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 8'(8'h10 + k), 5'd8, 1'b0);
      if (k == 6) chk("sw_settling_6", {31'd0, o_settling}, 32'd1);
      if (k == 7) chk("sw_settling_7", {31'd0, o_settling}, 32'd0);
    end
    idle(9, 5'd8);

    // stream at d=6, clear while presenting 0x40
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 5'd6, 1'b0);
    step(1'b1, 8'h40, 5'd6, 1'b1);
    chk("clr_delay", {27'd0, o_delay}, 32'd6);
    chk("clr_settling", {31'd0, o_settling}, 32'd0);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(8'h40 + i), 5'd6, 1'b0);
    chk("clr_settling_end", {31'd0, o_settling}, 32'd0);
    idle(7, 5'd6);

    // asynchronous reset in the middle of a d=3 stream
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h50 + i), 5'd3, 1'b0);
    #1 i_resetL = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, o_data}, 32'd0);
    chk("mid_rst_delay", {27'd0, o_delay}, 32'd1);
    chk("mid_rst_settling", {31'd0, o_settling}, 32'd0);
    sb.delete();
    mdl_d = DW'(RESET_DELAY);
    #1 i_resetL = 1'b1;
    step(1'b1, 8'h60, 5'd3, 1'b0);
    chk("post_rst_delay", {27'd0, o_delay}, 32'd3);
    chk("post_rst_settling_0", {31'd0, o_settling}, 32'd1);
    step(1'b1, 8'h61, 5'd3, 1'b0);
    chk("post_rst_settling_1", {31'd0, o_settling}, 32'd1);
    step(1'b1, 8'h62, 5'd3, 1'b0);
    chk("post_rst_settling_2", {31'd0, o_settling}, 32'd0);
    idle(4, 5'd3);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/variable_delay_line.md
Name: variable_delay_line

Overview:
- Parametrised successor to the fixed single-stage delayer: delays a WIDTH-bit data word plus its valid qualifier by a runtime-selectable number of clock cycles, 1..MAX_DELAY.
- Used in the UART datapath to align data and strobes with the control-unit timing (for example, matching the shifter and parity paths) without adding a separate delayer instance per offset.
- Adds the following, which a fixed delayer does not have: valid tracking, a synchronous flush, and safe on-the-fly delay changes with a settling indication.

Parameters:
- WIDTH, 8, data width in bits.
- MAX_DELAY, 16, number of pipeline stages and the largest selectable delay; must be ≥ 2.
- RESET_DELAY, 1, applied delay loaded at reset; range 1..MAX_DELAY.
- DW, $clog2(MAX_DELAY+1), width of the delay select and delay status ports.

Ports:
- i_clock, input, 1: rising-edge clock.
- i_resetL, input, 1: asynchronous active-low reset.
- i_clear, input, 1: synchronous flush of all in-flight samples.
- i_delay, input, DW: requested delay in cycles.
- i_valid, input, 1: qualifies i_data.
- i_data, input, WIDTH: sample to delay.
- o_valid, output, 1: delayed qualifier.
- o_data, output, WIDTH: delayed sample; forced to 0 whenever o_valid=0.
- o_delay, output, DW: currently applied delay.
- o_settling, output, 1: high while no flushed-in sample can yet reach the output after a delay change.

Behaviour:
- Reset (i_resetL=0, asynchronous, takes effect immediately):
  - all stage data regs = 0, all stage valid bits = 0;
  - applied delay d = RESET_DELAY;
  - settle counter = 0;
  - therefore o_valid=0, o_data=0, o_delay=RESET_DELAY, o_settling=0.
- Clamping: req = i_delay clamped to 1..MAX_DELAY (0 becomes 1; values above MAX_DELAY become MAX_DELAY).
- Pipeline, every rising edge out of reset:
  - stage[0] ← {i_valid, i_data};
  - stage[k] ← stage[k-1] for k = 1..MAX_DELAY-1.
- Output tap, combinational from registers only:
  - o_valid = v[d-1];
  - o_data = v[d-1] ? data[d-1] : 0.
  - There is no combinational path from any input to any output.
- Latency: a sample presented with i_valid=1 on edge E appears on o_valid/o_data during the cycle following edge E+d-1, i.e. exactly d cycles later. With d=1 the block matches a single flip-flop.
- Delay change: if req ≠ d at an edge E:
  - d ← req;
  - v[1..MAX_DELAY-1] ← 0, while v[0] ← i_valid (the sample presented at E is kept);
  - settle counter ← req-1.
  - Data registers shift normally.
  - Net effect: no sample is duplicated or emitted at the wrong latency. Samples in flight at E are dropped.
- Settle counter: decrements by 1 per edge while nonzero. o_settling = (counter ≠ 0). For req=1, o_settling stays 0.
- i_clear=1 at an edge:
  - v[1..MAX_DELAY-1] ← 0, v[0] ← i_valid;
  - d and the counter are unaffected, unless a delay change occurs on the same edge.
- i_clear together with a delay change on the same edge: both actions apply, and the result is identical to a delay change alone.
- Delay change during settling: d is reloaded, the pipeline is flushed again, and the counter restarts at the new req-1.
- Constant i_delay: no flushes occur; a continuous i_valid=1 stream is output gap-free after d cycles.
- Reset asserted mid-operation: state returns to the reset values immediately. After release, the first edge behaves as a normal shift. If i_delay ≠ RESET_DELAY at that edge, it is treated as a delay change.

Test Plan:
- Reset, then i_delay=1, with i_data = 0x11, 0x22, 0x33 on consecutive edges (i_valid=1) → o_data shows 0x11, 0x22, 0x33 one cycle later; o_valid=1 throughout; o_delay=1; o_settling=0.
- i_delay=5 steady, single pulse i_valid=1 with i_data=0xA5 at edge E → o_valid=1, o_data=0xA5 only in the cycle after edge E+4; o_data=0x00 in all other cycles.
- i_delay=MAX_DELAY+3 (19 with defaults) and i_delay=0 → o_delay reads 16 and 1 respectively; latency measured as 16 and 1 cycles.
- Continuous stream 0x01, 0x02, ... at d=4; switch i_delay to 8 at edge E while presenting 0x10:
  - samples 0x0D–0x0F are never output;
  - o_settling=1 for the 7 cycles after E;
  - 0x10 appears 8 cycles after E, followed by 0x11, 0x12, ... with no gaps.
- Stream at d=6; i_clear=1 at edge E with i_data=0x40, i_valid=1 → no outputs for 5 cycles; 0x40 appears 6 cycles after E; o_delay stays 6; o_settling stays 0.
- Stream at d=3; i_resetL pulled low asynchronously between edges:
  - o_valid=0, o_data=0, o_delay=RESET_DELAY immediately;
  - after release with i_delay=3, the first edge triggers a delay change: o_delay=3, o_settling high for 2 cycles.
